// File: rtl/data_mem_interface_pkg.sv
// Shared data-memory access definitions: access-size encodings and
// load-extension mode constants, also used by the load extender.
package data_mem_interface_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  localparam logic EXT_UNSIGNED = 1'b0;
  localparam logic EXT_SIGNED   = 1'b1;

endpackage

// File: rtl/data_mem_interface_byte_lane_steer.sv
// Combinational byte-lane steering: alignment check, byte enables,
// store-data replication and right-aligned, size-masked load data.
module byte_lane_steer
  import data_mem_interface_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_aligned
);

  logic [31:0] rdata_shifted;

  assign rdata_shifted = rdata >> {offset, 3'b000};

  always_comb begin
    aligned       = 1'b0;
    be            = '0;
    wdata_rep     = '0;
    rdata_aligned = '0;
    case (mem_size_e'(size))
      SIZE_BYTE: begin
        aligned       = 1'b1;
        be            = 4'b0001 << offset;
        wdata_rep     = {4{wdata[7:0]}};
        rdata_aligned = {24'h0, rdata_shifted[7:0]};
      end
      SIZE_HALF: begin
        aligned       = ~offset[0];
        be            = 4'b0011 << offset;
        wdata_rep     = {2{wdata[15:0]}};
        rdata_aligned = {16'h0, rdata_shifted[15:0]};
      end
      SIZE_WORD: begin
        aligned       = (offset == 2'b00);
        be            = 4'b1111;
        wdata_rep     = wdata;
        rdata_aligned = rdata_shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_interface.sv
// MEM-stage data-bus controller: alignment check, single outstanding
// word-addressed bus access with ack or timeout, pipeline stall control.
module data_mem_interface
  import data_mem_interface_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    size_q, off_q;
  logic [1:0]    steer_size, steer_off;
  logic          aligned;
  logic [3:0]    be;
  logic [31:0]   wdata_rep, rdata_aligned;
  logic          accept, misalign_hit, ack_hit, to_hit;

  // One steering instance serves both phases: request fields while idle,
  // latched size/offset while the access is outstanding.
  assign steer_size = (state_q == ST_IDLE) ? req_size_i      : size_q;
  assign steer_off  = (state_q == ST_IDLE) ? req_addr_i[1:0] : off_q;

  byte_lane_steer u_steer (
    .size          (steer_size),
    .offset        (steer_off),
    .wdata         (req_wdata_i),
    .rdata         (mem_rdata_i),
    .aligned       (aligned),
    .be            (be),
    .wdata_rep     (wdata_rep),
    .rdata_aligned (rdata_aligned)
  );

  assign accept       = (state_q == ST_IDLE) && req_valid_i && aligned;
  assign misalign_hit = (state_q == ST_IDLE) && req_valid_i && !aligned;
  assign ack_hit      = (state_q == ST_BUSY) && mem_ack_i;
  assign to_hit       = (state_q == ST_BUSY) && !mem_ack_i && (cnt_q == CW'(TIMEOUT - 1));

  assign stall_o = accept || (state_q == ST_BUSY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (ack_hit || to_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      size_q      <= '0;
      off_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      load_data_o <= '0;
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_o     <= ack_hit || to_hit;
      misalign_o <= misalign_hit;
      bus_err_o  <= to_hit;
      if (accept) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= req_write_i;
        mem_addr_o  <= {req_addr_i[31:2], 2'b00};
        mem_wdata_o <= wdata_rep;
        mem_be_o    <= be;
        size_q      <= req_size_i;
        off_q       <= req_addr_i[1:0];
        cnt_q       <= '0;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
        if (ack_hit) begin
          mem_req_o   <= 1'b0;
          load_data_o <= mem_we_o ? '0 : rdata_aligned;
        end else if (to_hit) begin
          mem_req_o   <= 1'b0;
          load_data_o <= '0;
        end
      end
    end
  end

endmodule

// File: doc/data_mem_interface.md
# data_mem_interface

Memory-stage data-bus controller for the pipelined RV32I core. Takes load/store requests from the MEM stage, checks alignment, drives a word-addressed data-memory bus with byte enables, and stalls the pipeline until the bus acknowledges. Returns load data right-aligned and zero-masked to the access size. That data feeds the load extender, which performs sign/zero extension.

## Interface
Parameters:
- TIMEOUT, 255: number of BUSY cycles without `mem_ack_i` before a bus error is declared. Must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  MEM stage holds a load/store.
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- req_size_i  in  2  `Byte` / `Half` / `Word` encoding.
- stall_o  out  1  holds the pipeline (combinational).
- mem_req_o  out  1  bus request (registered).
- mem_we_o  out  1  bus write.
- mem_addr_o  out  32  word-aligned address, `{addr[31:2], 2'b00}`.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_be_o  out  4  byte enables.
- mem_ack_i  in  1  bus completion; `mem_rdata_i` is valid in the same cycle.
- mem_rdata_i  in  32  read word.
- load_data_o  out  32  right-aligned, size-masked load data for the load extender.
- done_o  out  1  one-cycle completion pulse.
- misalign_o  out  1  one-cycle misaligned-access pulse.
- bus_err_o  out  1  one-cycle timeout pulse.

## Operation
- States: IDLE, BUSY, DONE.
- Alignment check:
  - `Half` requires `addr[0]==0`.
  - `Word` requires `addr[1:0]==0`.
  - `Byte` is always aligned.
  - Size encoding `2'b11` is treated as misaligned.
- IDLE, request valid and aligned:
  - Latch `we`, `addr`, `size`, `offset = addr[1:0]`, `be` and `wdata`.
  - Set `mem_req_o`.
  - Next state BUSY.
- IDLE, request valid and misaligned:
  - Pulse `misalign_o` on the next cycle.
  - No bus request; remain in IDLE.
  - `stall_o` stays low, so the trap logic consumes the instruction.
- Byte enables: `Byte` = `4'b0001<<off`, `Half` = `4'b0011<<off`, `Word` = `4'b1111`.
- Store data: `Byte` = `{4{wdata[7:0]}}`, `Half` = `{2{wdata[15:0]}}`, `Word` = `wdata`.
- BUSY:
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_be_o` and `mem_wdata_o` are held stable.
  - A counter increments each cycle.
- BUSY with `mem_ack_i`:
  - Drop `mem_req_o`.
  - Loads: `load_data_o = (rdata >> 8*off)` masked to 8/16/32 bits.
  - Stores: `load_data_o = 0`.
  - Next state DONE.
- BUSY with counter reaching TIMEOUT and no ack:
  - Drop `mem_req_o`, set `load_data_o = 0`, pulse `bus_err_o`.
  - Next state DONE.
  - If ack and timeout coincide, the ack wins and `bus_err_o` stays low.
- DONE:
  - `done_o = 1`, `stall_o = 0`; the held instruction advances.
  - `req_valid_i` is ignored.
  - Next state IDLE.
- `stall_o = (IDLE & req_valid_i & aligned) | BUSY`.
- `load_data_o` holds its value until the next completion.
- Counter: width `$clog2(TIMEOUT+1)`; clears on entry to BUSY.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o`, `load_data_o`, `done_o`, `misalign_o`, `bus_err_o` all 0.
- Request accepted in cycle 0 → `mem_req_o` is high in cycle 1.
- Ack in cycle k (k ≥ 1) → `done_o` and new `load_data_o` in cycle k+1.
- Minimum latency: 2 cycles of stall, done in cycle 2.
- Timeout: `bus_err_o` and `done_o` in cycle TIMEOUT+1 after acceptance.
- Back-to-back accesses: a new request is accepted in the cycle after DONE.
- `rst` during BUSY abandons the access:
  - `mem_req_o` is 0 the next cycle.
  - No `done_o`, `bus_err_o` or `misalign_o` pulse.
  - A late ack while in IDLE is ignored.

## Structure
- Shared definitions header/package (existing): the `Byte`/`Half`/`Word` size encodings and the `Signed`/`Unsigned` constants. These are shared with the load extender.
- State enum and counter width stay local to the module.
- One combinational sub-module, `byte_lane_steer`:
  - Inputs: size, offset, wdata, rdata.
  - Outputs: be, replicated wdata, aligned and masked rdata.
  - Also produces the `aligned` flag.
- The FSM, latches and counter live in `data_mem_interface`.

## Test plan
- Byte load, `addr=0x1003`, ack 2 cycles after `mem_req_o`, `rdata=0xAABBCCDD` → `mem_addr_o=0x1000`, `mem_be_o=4'b1000`, `load_data_o=0x000000AA`, single `done_o` pulse, `stall_o` high for 3 cycles.
- Half store, `addr=0x2002`, `wdata=0x1234ABCD` → `mem_we_o=1`, `mem_be_o=4'b1100`, `mem_wdata_o=0xABCDABCD`, `done_o` after ack, `load_data_o=0`.
- Word load, `addr=0x3001`; then `Half` at `0x3003` → `misalign_o` pulse each; `mem_req_o` never high; `stall_o` low throughout.
- TIMEOUT=4, no ack → `bus_err_o` and `done_o` in cycle 5; `mem_req_o` low from cycle 5. Repeat with ack in the 4th BUSY cycle → `done_o`, no `bus_err_o`.
- Word load acked in the first BUSY cycle, `rdata=0xDEADBEEF`, immediately followed by a byte load to `0x0002` with `rdata=0x00550000` → first `load_data_o=0xDEADBEEF`, second `=0x00000055`; request accepted in the cycle after DONE.
- `rst` asserted mid-BUSY, then a stray `mem_ack_i` → `mem_req_o=0` next cycle; all outputs 0; no pulses; state IDLE.
